uart_tx_arbiter: RTL and testbench

- Shares one byte-wide UART transmitter (e.g. the uart_0 TX channel) between NREQ requesters.
- Arbitration is round-robin at packet granularity. Once a requester is granted, it owns the transmitter until it sends a byte flagged last, or until an idle timeout forces release.
- Sits between requester logic (command/response engines) and the UART core's byte interface. Exports a 4-bit status suitable for the board LEDs.

---
 rtl/uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one byte-wide UART transmitter between NREQ requesters.
// Arbitration is round-robin and happens once per packet. The current owner
// keeps the transmitter until it sends a byte flagged last, or until a forced
// release. A forced release is caused by an idle owner in LOAD, or by a
// transmitter that never raises busy. Every output is driven from a register.

module uart_tx_arbiter #(
  parameter int NREQ    = 2,     // number of requesters, 2..4
  parameter int DATA_W  = 8,     // byte width
  parameter int TIMEOUT = 1023,  // idle LOAD cycles tolerated before forced release
  parameter int CNT_W   = 10     // timeout counter width, must be able to hold TIMEOUT
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          grant,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  input  logic                     clr_err,
  output logic                     timeout_err,
  output logic [3:0]               status
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  // Owner and pointer indices are always 2 bits wide, which covers up to 4 requesters.
  // The same 2 bits are reported on status[3:2].
  localparam logic [1:0]       PTR_RST   = 2'(NREQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [1:0]       SEND_MAX  = 2'd3;  // last SEND cycle in which busy may rise

  state_e              state_q;
  logic [NREQ-1:0]     grant_q;
  logic [NREQ-1:0]     req_ready_q;
  logic [1:0]          owner_q;
  logic [1:0]          ptr_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_start_q;
  logic                last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          send_cnt_q;
  logic                timeout_err_q;
  logic                sticky_q;
  logic                lock_q;

  // Request inputs are padded out to four entries.
  // This lets a 2-bit owner index select an entry safely for any NREQ.
  logic [3:0]          valid_pad;
  logic [3:0]          last_pad;
  logic [DATA_W-1:0]   data_arr [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NREQ) begin : g_used
        assign valid_pad[gi] = req_valid[gi];
        assign last_pad[gi]  = req_last[gi];
        assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
      end else begin : g_unused
        assign valid_pad[gi] = 1'b0;
        assign last_pad[gi]  = 1'b0;
        assign data_arr[gi]  = '0;
      end
    end
  endgenerate

  logic                owner_valid;
  logic                owner_last;
  logic [DATA_W-1:0]   owner_data;

  assign owner_valid = valid_pad[owner_q];
  assign owner_last  = last_pad[owner_q];
  assign owner_data  = data_arr[owner_q];

  logic                win_found;
  logic [1:0]          win_idx;
  logic [2:0]          cand;

  // Round-robin search: take the first valid requester after the pointer, wrapping round.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      if (!win_found && valid_pad[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  // Packet-lock FSM. All outputs are updated here, so every output is registered.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      req_ready_q   <= '0;
      owner_q       <= '0;
      ptr_q         <= PTR_RST;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      send_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      sticky_q      <= 1'b0;
      lock_q        <= 1'b0;
    end else begin
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      // A forced release later in this block sets sticky_q again.
      // That later assignment wins, so a set in the same cycle as a clear takes priority.
      if (clr_err) begin
        sticky_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_q     <= NREQ'(1) << win_idx;
            req_ready_q <= NREQ'(1) << win_idx;
            owner_q     <= win_idx;
            cnt_q       <= '0;
            lock_q      <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (owner_valid) begin
            tx_data_q   <= owner_data;
            last_q      <= owner_last;
            cnt_q       <= '0;
            send_cnt_q  <= '0;
            tx_start_q  <= 1'b1;
            req_ready_q <= '0;
            state_q     <= ST_SEND;
          end else if (cnt_q == TIMEOUT_C) begin
            // The owner went quiet mid-packet: force a release and flag it.
            timeout_err_q <= 1'b1;
            sticky_q      <= 1'b1;
            grant_q       <= '0;
            req_ready_q   <= '0;
            ptr_q         <= owner_q;
            owner_q       <= '0;
            lock_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SEND: begin
          if (tx_busy) begin
            state_q <= ST_WAIT;
          end else if (send_cnt_q == SEND_MAX) begin
            // The transmitter never acknowledged the start pulse: treat it as a failed handshake.
            timeout_err_q <= 1'b1;
            sticky_q      <= 1'b1;
            grant_q       <= '0;
            req_ready_q   <= '0;
            ptr_q         <= owner_q;
            owner_q       <= '0;
            lock_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            send_cnt_q <= send_cnt_q + 1'b1;
          end
        end

        ST_WAIT: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= owner_q;
              owner_q <= '0;
              lock_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              req_ready_q <= grant_q;
              cnt_q       <= '0;
              state_q     <= ST_LOAD;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign timeout_err = timeout_err_q;
  assign status      = {owner_q, sticky_q, lock_q};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NREQ=2, TIMEOUT=15).
// A small transmitter model answers tx_start with a busy window. The
// stimulus is one linear sequence of steps, and each check is an
// immediate assertion.

module tb_uart_tx_arbiter;

  localparam int NREQ    = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 10;
  localparam int BUDGET  = 200;

  logic                   clk_clk;
  logic                   reset_reset_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        grant;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic                   clr_err;
  logic                   timeout_err;
  logic [3:0]             status;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transmitter model settings.
  int busy_delay = 0;
  int busy_len   = 10;
  bit busy_never = 1'b0;

  // Lock observer.
  bit lock_window = 1'b0;
  int lock_viol   = 0;

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .clr_err      (clr_err),
    .timeout_err  (timeout_err),
    .status       (status)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  // Transmitter model: busy rises busy_delay cycles after a start pulse and lasts busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk_clk); #1;
      if (tx_start === 1'b1 && !busy_never) begin
        repeat (busy_delay) begin @(posedge clk_clk); #1; end
        tx_busy = 1'b1;
        repeat (busy_len) begin @(posedge clk_clk); #1; end
        tx_busy = 1'b0;
      end
    end
  end

  // Counts any cycle in which requester 1 sees ready while requester 0 holds the lock.
  initial begin
    forever begin
      @(negedge clk_clk);
      if (lock_window && req_ready[1] === 1'b1) lock_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ready(input int i, input string tag);
    int n = 0;
    while (req_ready[i] !== 1'b1 && n < BUDGET) begin @(negedge clk_clk); n++; end
    check({tag, "_ready"}, 32'(req_ready[i]), 32'd1);
  endtask

  task automatic wait_grant_nz(input logic [NREQ-1:0] exp, input string tag);
    int n = 0;
    while (grant === '0 && n < BUDGET) begin @(negedge clk_clk); n++; end
    check({tag, "_grant"}, 32'(grant), 32'(exp));
  endtask

  task automatic wait_grant_zero(input string tag);
    int n = 0;
    while (grant !== '0 && n < BUDGET) begin @(negedge clk_clk); n++; end
    check({tag, "_release"}, 32'(grant), 32'd0);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx_start !== 1'b1 && n < BUDGET) begin @(negedge clk_clk); n++; end
    check({tag, "_start"}, 32'(tx_start), 32'd1);
  endtask

  task automatic wait_busy_low(input string tag);
    int n = 0;
    while (tx_busy !== 1'b0 && n < BUDGET) begin @(negedge clk_clk); n++; end
    check({tag, "_busylow"}, 32'(tx_busy), 32'd0);
  endtask

  // Present one byte from requester i and wait for it to be accepted.
  // Then check the start pulse and data, and that both hold correctly one cycle later.
  task automatic xfer(input int i, input logic [7:0] b, input logic l, input string tag);
    logic [NREQ-1:0] exp_g;
    exp_g = NREQ'(1) << i;
    req_data[i*DATA_W +: DATA_W] = b;
    req_last[i]  = l;
    req_valid[i] = 1'b1;
    wait_ready(i, tag);
    @(negedge clk_clk);
    check({tag, "_start"}, 32'(tx_start), 32'd1);
    check({tag, "_data"},  32'(tx_data),  32'(b));
    check({tag, "_grant"}, 32'(grant),    32'(exp_g));
    check({tag, "_rdy0"},  32'(req_ready), 32'd0);
    if (l) req_valid[i] = 1'b0;
    @(negedge clk_clk);
    check({tag, "_start1"}, 32'(tx_start), 32'd0);
    check({tag, "_hold"},   32'(tx_data),  32'(b));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},  32'(grant),       32'd0);
    check({tag, "_ready"},  32'(req_ready),   32'd0);
    check({tag, "_txdata"}, 32'(tx_data),     32'd0);
    check({tag, "_txstart"},32'(tx_start),    32'd0);
    check({tag, "_tmo"},    32'(timeout_err), 32'd0);
    check({tag, "_status"}, 32'(status),      32'd0);
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    check_reset_outputs("rst");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  initial begin
    reset_reset_n = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    req_last      = '0;
    clr_err       = 1'b0;

    // Reset state
    @(negedge clk_clk);
    check_reset_outputs("init");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // Single packet from req0: 0x41, 0x42, 0x43 (last)
    req_data[7:0] = 8'h41;
    req_last[0]   = 1'b0;
    req_valid[0]  = 1'b1;
    @(negedge clk_clk);
    check("p1_arb_grant",  32'(grant),     32'h1);
    check("p1_arb_ready",  32'(req_ready), 32'h1);
    check("p1_arb_status", 32'(status),    32'h1);
    xfer(0, 8'h41, 1'b0, "p1_b0");
    xfer(0, 8'h42, 1'b0, "p1_b1");
    xfer(0, 8'h43, 1'b1, "p1_b2");
    wait_busy_low("p1");
    check("p1_grant_at_fall", 32'(grant), 32'h1);
    @(negedge clk_clk);
    check("p1_grant_after",  32'(grant),  32'h0);
    check("p1_status_after", 32'(status), 32'h0);

    // Fairness after reset: both requesters continuously valid with 1-byte packets
    do_reset();
    req_data    = {8'hB1, 8'hA0};
    req_last    = 2'b11;
    req_valid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant_nz((k % 2 == 0) ? 2'b01 : 2'b10, $sformatf("fair%0d", k));
      wait_start($sformatf("fair%0d", k));
      check($sformatf("fair%0d_data", k), 32'(tx_data), (k % 2 == 0) ? 32'hA0 : 32'hB1);
      if (k == 3) req_valid = 2'b00;
      wait_grant_zero($sformatf("fair%0d", k));
    end

    // Lock: req0 sends a 3-byte packet while req1 waits with its valid held high
    req_data[7:0] = 8'h51;
    req_last[0]   = 1'b0;
    req_valid[0]  = 1'b1;
    @(negedge clk_clk);
    check("lock_first_grant", 32'(grant), 32'h1);
    req_data[15:8] = 8'h61;
    req_last[1]    = 1'b1;
    req_valid[1]   = 1'b1;
    lock_window    = 1'b1;
    xfer(0, 8'h51, 1'b0, "lock_b0");
    xfer(0, 8'h52, 1'b0, "lock_b1");
    xfer(0, 8'h53, 1'b1, "lock_b2");
    wait_busy_low("lock");
    check("lock_grant_at_fall", 32'(grant), 32'h1);
    @(negedge clk_clk);
    check("lock_grant_release", 32'(grant), 32'h0);
    lock_window = 1'b0;
    check("lock_no_req1_ready", 32'(lock_viol), 32'd0);
    @(negedge clk_clk);
    check("lock_req1_grant", 32'(grant), 32'h2);
    xfer(1, 8'h61, 1'b1, "lock_r1");
    wait_grant_zero("lock_r1");

    // Idle timeout: one non-last byte, then the owner goes quiet in LOAD
    begin
      int n_rdy;
      int n;
      xfer(0, 8'h71, 1'b0, "tmo_b0");
      req_valid[0] = 1'b0;
      wait_busy_low("tmo");
      @(negedge clk_clk);
      n_rdy = 0;
      n     = 0;
      while (timeout_err !== 1'b1 && n < BUDGET) begin
        if (req_ready[0] === 1'b1) n_rdy++;
        @(negedge clk_clk);
        n++;
      end
      check("tmo_pulse",      32'(timeout_err), 32'd1);
      check("tmo_load_cycles", 32'(n_rdy),      32'(TIMEOUT + 1));
      check("tmo_grant",      32'(grant),       32'h0);
      check("tmo_ready",      32'(req_ready),   32'h0);
      check("tmo_status",     32'(status),      32'h2);
      @(negedge clk_clk);
      check("tmo_pulse_end",  32'(timeout_err), 32'd0);
      check("tmo_sticky",     32'(status),      32'h2);
      clr_err = 1'b1;
      @(negedge clk_clk);
      clr_err = 1'b0;
      check("tmo_cleared",    32'(status),      32'h0);
    end

    // Slow transmitter: busy rises 3 cycles after tx_start
    busy_delay = 3;
    xfer(0, 8'h81, 1'b1, "slow");
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_clk);
      check($sformatf("slow_nostart%0d", j), 32'(tx_start),    32'd0);
      check($sformatf("slow_data%0d", j),    32'(tx_data),     32'h81);
      check($sformatf("slow_notmo%0d", j),   32'(timeout_err), 32'd0);
    end
    wait_busy_low("slow");
    @(negedge clk_clk);
    check("slow_release", 32'(grant), 32'h0);
    busy_delay = 0;

    // Transmitter never answers: handshake failure after 4 SEND cycles; set beats a held clear
    busy_never = 1'b1;
    clr_err    = 1'b1;
    xfer(0, 8'h91, 1'b1, "dead");
    @(negedge clk_clk);
    check("dead_notmo_s2", 32'(timeout_err), 32'd0);
    @(negedge clk_clk);
    check("dead_notmo_s3", 32'(timeout_err), 32'd0);
    @(negedge clk_clk);
    check("dead_tmo",      32'(timeout_err), 32'd1);
    check("dead_grant",    32'(grant),       32'h0);
    check("dead_setwins",  32'(status),      32'h2);
    @(negedge clk_clk);
    check("dead_tmo_end",  32'(timeout_err), 32'd0);
    check("dead_cleared",  32'(status),      32'h0);
    clr_err    = 1'b0;
    busy_never = 1'b0;

    // Reset mid-packet, asserted while the owner is in WAIT
    xfer(0, 8'hC1, 1'b0, "mid");
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_async");
    req_valid[0]   = 1'b0;
    req_data[15:8] = 8'hD1;
    req_last[1]    = 1'b1;
    req_valid[1]   = 1'b1;
    @(negedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check("mid_req1_grant",  32'(grant),  32'h2);
    check("mid_req1_status", 32'(status), 32'h5);
    xfer(1, 8'hD1, 1'b1, "mid_r1");
    wait_grant_zero("mid_r1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
